// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state type
// and small op-decode helpers.
// Latency: n/a (definitions only). Backpressure: n/a.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    // op[1] selects divide, op[0] selects signed operands
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
// Latency: combinational. Backpressure: none, evaluated every cycle by the caller.
// Ports: div selects divide; acc/q are the running {high,low} pair, m the fixed operand magnitude.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH-1:0] madd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;

    always_comb begin
        // multiply: add m when the current multiplier bit is set, then shift {acc,q} right
        madd = q[0] ? m : '0;
        sum  = {1'b0, acc} + {1'b0, madd};
        // divide: bring the next dividend bit into the partial remainder and trial-subtract.
        // The remainder is always < m, so diff[WIDTH] is a clean borrow flag.
        shl  = {acc, q[WIDTH-1]};
        diff = shl - {1'b0, m};

        acc_nxt = sum[WIDTH:1];
        q_nxt   = {sum[0], q[WIDTH-1:1]};
        if (div) begin
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shl[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit (multu, mult, divu, div) with sign fix-up.
// Latency: done pulses WIDTH+2 edges after start is accepted (start edge counted).
// Backpressure: start is ignored while busy; results held on hi/lo until next done.
// Ports: clk, reset (sync, active-high), start/op/a/b request, busy, done, hi, lo, div_by_zero.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [CNTW-1:0]  cnt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last;

    logic             a_sgn;
    logic             b_sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_dz;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div     (is_div_op(op_r)),
        .acc     (acc),
        .q       (q),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    assign last = (cnt == CNTW'(WIDTH - 1));

    // operand magnitudes; the most-negative value maps onto itself, which reads
    // correctly as an unsigned magnitude
    always_comb begin
        a_sgn = is_signed_op(op) & a[WIDTH-1];
        b_sgn = is_signed_op(op) & b[WIDTH-1];
        a_mag = a_sgn ? -a : a;
        b_mag = b_sgn ? -b : b;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // sign fix-up; {acc,q} holds the magnitude product, or remainder/quotient
    always_comb begin
        prod   = {acc, q};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        res_dz = 1'b0;
        if (!is_div_op(op_r)) begin
            if (a_neg ^ b_neg) begin
                prod   = -prod;
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
            end
        end else if (b_zero) begin
            res_hi = a_r;
            res_lo = '1;
            res_dz = 1'b1;
        end else begin
            res_lo = (a_neg ^ b_neg) ? -q : q;
            res_hi = a_neg ? -acc : acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            op_r        <= OP_MULTU;
            a_r         <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            b_zero      <= 1'b0;
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        a_r    <= a;
                        a_neg  <= a_sgn;
                        b_neg  <= b_sgn;
                        b_zero <= (b == '0);
                        acc    <= '0;
                        // multiply is commutative, so both ops iterate over |a| with m = |b|
                        q      <= a_mag;
                        m      <= b_mag;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CNTW'(1);
                end
                FIX: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= res_dz;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors, random ops against a behavioural
// model, ignored start while busy, and reset abort mid-operation.
module tb_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    always #5 clk = ~clk;

    mdu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
        string        tag;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint      sx;
        longint      sy;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (y == '0) begin
                    eh = x; el = '1; ed = 1'b1;
                end else if (o == 2'b10) begin
                    el = x / y; eh = x % y;
                end else begin
                    r = sx / sy; el = r[31:0];
                    r = sx % sy; eh = r[31:0];
                end
            end
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pop scoreboard on done, check value, latency and busy span
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk({e.tag, "_hi"}, hi, e.hi);
                chk({e.tag, "_lo"}, lo, e.lo);
                chk({e.tag, "_dz"}, dbz, e.dz);
                chk({e.tag, "_lat"}, cyc - e.cyc, W + 1);
                chk({e.tag, "_busy"}, busy_run, W + 1);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end
    end

    task automatic issue(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({tag, "_busy_timeout"}, 64'd1, 64'd0);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        e.hi  = eh;
        e.lo  = el;
        e.dz  = ed;
        e.cyc = cyc;
        e.tag = tag;
        sbq.push_back(e);
        // scramble inputs so a design that keeps sampling them is caught
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic issue_model(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        model(o, x, y, eh, el, ed);
        issue(tag, o, x, y, eh, el, ed);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dz", dbz, 0);
        reset = 1'b0;

        issue("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue("div_neg",    2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue("divu_small", 2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
        issue("divu_zero",  2'b10, 32'h0FB7_AFF0, 32'h0000_0000, 32'h0FB7_AFF0, 32'hFFFF_FFFF, 1'b1);
        issue("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue("div_zero_s", 2'b11, 32'h8000_0005, 32'h0000_0000, 32'h8000_0005, 32'hFFFF_FFFF, 1'b1);
        issue("div_rem_neg",2'b11, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            issue_model($sformatf("rand%0d", i), 2'($urandom), pick(), pick());
        end
        drain();

        // start pulses while busy must be ignored
        issue("ignore_start", 2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'h0000_1234; b = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h0000_0011; b = 32'h0000_0022;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // reset mid-operation aborts with no done and clears outputs
        issue_model("aborted", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sbq.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_dz", dbz, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done, 0);

        issue("after_reset", 2'b11, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
